// File: rtl/sample_seq_pkg.sv
// Shared FSM state type and uio bit positions for the sample sequencer.
package sample_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    // uio_in control bits
    localparam int CAP_BIT   = 0;
    localparam int PLAY_BIT  = 1;
    localparam int ABORT_BIT = 2;

    // uio_out status bits
    localparam int CAPTURING_BIT = 4;
    localparam int PLAYING_BIT   = 5;
    localparam int FULL_BIT      = 6;
    localparam int DONE_BIT      = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every TICK_DIV enabled cycles after a clear.
module sample_tick_gen #(
    parameter logic [23:0] TICK_DIV = 24'd10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [23:0] LAST = TICK_DIV - 24'd1;

    logic [23:0] cnt;

    assign tick = enable && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 24'd1;
        end
    end

endmodule

// File: rtl/tt_um_sample_sequencer.sv
// Capture/playback sample sequencer. Define SAMPLE_SEQ_LOOP_PLAY_EN for looping playback
// until abort; the default build plays the buffer once.
module tt_um_sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter logic [23:0] TICK_DIV = 24'd10_000,
    parameter int          DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t           state;
    logic [2:0]       ctl_s;
    logic [2:0]       ctl_p;
    logic [2:0]       ctl_rise;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             done;
    logic [7:0]       play_data;
    logic [7:0]       sample_buf [DEPTH];
    logic             tick;
    logic             start_cap;
    logic             start_play;
    logic             last_read;
    logic             unused_ctl;

    assign unused_ctl = &{1'b0, uio_in[7:3]};

    assign ctl_rise   = ctl_s & ~ctl_p;
    assign start_cap  = (state == ST_IDLE) && ctl_rise[CAP_BIT] && !ctl_rise[ABORT_BIT];
    assign start_play = (state == ST_IDLE) && ctl_rise[PLAY_BIT] && !ctl_rise[CAP_BIT]
                        && !ctl_rise[ABORT_BIT] && (count != '0);
    assign last_read  = ({1'b0, rd_ptr} == count - CNT_W'(1));

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ena && (start_cap || start_play)),
        .enable (ena && (state != ST_IDLE)),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ctl_s     <= '0;
            ctl_p     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            done      <= 1'b0;
            play_data <= '0;
        end else if (ena) begin
            ctl_s <= uio_in[2:0];
            ctl_p <= ctl_s;
            case (state)
                ST_IDLE: begin
                    if (start_cap) begin
                        count  <= '0;
                        wr_ptr <= '0;
                        full   <= 1'b0;
                        done   <= 1'b0;
                        state  <= ST_CAPTURE;
                    end else if (start_play) begin
                        rd_ptr <= '0;
                        done   <= 1'b0;
                        state  <= ST_PLAY;
                    end
                end
                ST_CAPTURE: begin
                    if (tick) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        count  <= count + CNT_W'(1);
                        if (wr_ptr == LAST_PTR) begin
                            full  <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    if (ctl_rise[ABORT_BIT]) state <= ST_IDLE;
                end
                ST_PLAY: begin
                    if (tick) begin
                        play_data <= sample_buf[rd_ptr];
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        if (last_read) begin
`ifdef SAMPLE_SEQ_LOOP_PLAY_EN
                            rd_ptr <= '0;
`else
                            done  <= 1'b1;
                            state <= ST_IDLE;
`endif
                        end
                    end
                    // An abort on a tick cycle still lets that tick's read land first.
                    if (ctl_rise[ABORT_BIT]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the sample memory has no reset so it maps onto plain storage without a reset net.
    always_ff @(posedge clk) begin
        if (tick && (state == ST_CAPTURE)) sample_buf[wr_ptr] <= ui_in;
    end

    // NOTE: every output bit gets a default first so no latch is inferred.
    always_comb begin
        uio_out                = 8'h00;
        uio_out[CAPTURING_BIT] = (state == ST_CAPTURE);
        uio_out[PLAYING_BIT]   = (state == ST_PLAY);
        uio_out[FULL_BIT]      = full;
        uio_out[DONE_BIT]      = done;
    end

    assign uo_out = play_data;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_sample_sequencer.sv
// Directed-sequence bench for tt_um_sample_sequencer with random sample data and a queue-based model.
module tb_tt_um_sample_sequencer;
    import sample_seq_pkg::*;

    localparam int TD    = 4;
    localparam int DEPTH = 4;
`ifdef SAMPLE_SEQ_LOOP_PLAY_EN
    localparam bit ONE_SHOT = 1'b0;
`else
    localparam bit ONE_SHOT = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: captured samples in order, last played value, sticky flags.
    logic [7:0] ref_buf[$];
    logic [7:0] ref_uo;
    bit         ref_full;
    bit         ref_done;

    always #5 clk = ~clk;

    tt_um_sample_sequencer #(.TICK_DIV(24'(TD)), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Status nibble is {done, full, playing, capturing}.
    task automatic check_status(input string tag, input logic [3:0] exp);
        check(tag, {4'h0, uio_out[7:4]}, {4'h0, exp});
    endtask

    task automatic pulse(input logic [2:0] mask);
        uio_in = {5'($urandom), mask};
        @(negedge clk);
        uio_in = {5'($urandom), 3'b000};
    endtask

    function automatic int reads();
        return ONE_SHOT ? ref_buf.size() : 2 * ref_buf.size() + 1;
    endfunction

    task automatic capture(input int n, input int freeze_k, input bit do_abort, input bit fixed);
        logic [7:0] d;
        int pre;
        pulse(3'b001);
        ref_buf.delete();
        ref_full = 1'b0;
        ref_done = 1'b0;
        for (int k = 0; k < n; k++) begin
            d     = fixed ? 8'((k + 1) * 17) : 8'($urandom);
            ui_in = d;
            pre   = (k == 0) ? TD : TD - 1;
            for (int c = 0; c < pre; c++) begin
                if (c == 0 && k == freeze_k) begin
                    ena   = 1'b0;
                    ui_in = ~d;
                    repeat (10) @(negedge clk);
                    check_status("freeze_hold", {ref_done, ref_full, 1'b0, 1'b1});
                    ui_in = d;
                    ena   = 1'b1;
                end
                @(negedge clk);
            end
            check_status("cap_pre", {ref_done, ref_full, 1'b0, 1'b1});
            @(negedge clk);
            ref_buf.push_back(d);
            if (ref_buf.size() == DEPTH) begin
                ref_full = 1'b1;
                ref_done = 1'b1;
            end
            check_status("cap_post", {ref_done, ref_full, 1'b0, (ref_buf.size() < DEPTH)});
        end
        if (do_abort) begin
            pulse(3'b100);
            @(negedge clk);
            check_status("cap_abort", 4'b0000);
        end
    endtask

    task automatic play(input int nreads, input int abort_at, input bit poke_cap);
        int pre;
        bit last;
        ui_in = 8'($urandom);
        pulse(3'b010);
        ref_done = 1'b0;
        for (int r = 0; r < nreads; r++) begin
            pre = (r == 0) ? TD : TD - 1;
            for (int c = 0; c < pre; c++) begin
                uio_in[CAP_BIT]   = poke_cap && (r == 0) && (c == 0);
                uio_in[ABORT_BIT] = (r == abort_at) && (c == pre - 1);
                @(negedge clk);
            end
            uio_in = 8'h00;
            check("play_hold", uo_out, ref_uo);
            check_status("play_pre", {ref_done, ref_full, 1'b1, 1'b0});
            @(negedge clk);
            ref_uo = ref_buf[r % ref_buf.size()];
            check("play_data", uo_out, ref_uo);
            if (r == abort_at) begin
                check_status("play_abort_tick", {1'b0, ref_full, 2'b00});
                return;
            end
            last = (r == nreads - 1) && ONE_SHOT;
            if (last) ref_done = 1'b1;
            check_status("play_post", {ref_done, ref_full, !last, 1'b0});
        end
`ifdef SAMPLE_SEQ_LOOP_PLAY_EN
        pulse(3'b100);
        @(negedge clk);
        check_status("loop_abort", {1'b0, ref_full, 2'b00});
`endif
        repeat (TD + 2) @(negedge clk);
        check("play_idle_hold", uo_out, ref_uo);
        check_status("play_idle_status", {ref_done, ref_full, 2'b00});
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        ref_uo   = 8'h00;
        ref_full = 1'b0;
        ref_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        @(negedge clk);

        // Play with nothing captured is ignored.
        pulse(3'b010);
        repeat (TD + 2) @(negedge clk);
        check("empty_play_uo", uo_out, 8'h00);
        check_status("empty_play_status", 4'b0000);

        // Simultaneous capture and play requests: capture wins.
        pulse(3'b011);
        @(negedge clk);
        check_status("cap_wins", 4'b0001);
        pulse(3'b100);
        @(negedge clk);
        check_status("early_abort", 4'b0000);
        pulse(3'b010);
        repeat (TD + 2) @(negedge clk);
        check_status("empty_after_abort", 4'b0000);
        check("empty_after_abort_uo", uo_out, 8'h00);

        // Full capture of 11,22,33,44, then playback with a stray cap request mid-play.
        capture(DEPTH, -1, 1'b0, 1'b1);
        play(reads(), -1, 1'b1);

        // Full capture with ena dropped for 10 cycles before the last write.
        capture(DEPTH, DEPTH - 1, 1'b0, 1'b0);
        play(reads(), -1, 1'b0);

        // Partial captures ended by abort.
        capture(2, -1, 1'b1, 1'b0);
        play(reads(), -1, 1'b0);
        capture(DEPTH - 1, -1, 1'b1, 1'b0);
        play(reads(), -1, 1'b0);

        // Abort coincident with a playback tick.
        capture(DEPTH, -1, 1'b0, 1'b0);
        play(reads(), $urandom_range(0, DEPTH - 2), 1'b0);
        repeat (TD + 2) @(negedge clk);
        check("abort_tick_hold", uo_out, ref_uo);
        check_status("abort_tick_idle", {1'b0, ref_full, 2'b00});

        // Reset in the middle of playback.
        pulse(3'b010);
        ref_done = 1'b0;
        repeat (TD + 1) @(negedge clk);
        ref_uo = ref_buf[0];
        check("rstplay_first", uo_out, ref_uo);
        check_status("rstplay_active", {1'b0, ref_full, 2'b10});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        ref_buf.delete();
        ref_uo   = 8'h00;
        ref_full = 1'b0;
        ref_done = 1'b0;
        check("rst_mid_uo", uo_out, ref_uo);
        check_status("rst_mid_status", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(3'b010);
        repeat (TD + 2) @(negedge clk);
        check("post_rst_play_uo", uo_out, ref_uo);
        check_status("post_rst_play_status", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
